tdm_demux1x4: RTL

Time-division demultiplexer: the receiving end of a 4-to-1 channel multiplexer link. It takes one shared data lane carrying four channels in rotating slots (slot 0..3, slot 0 tagged by a `sync` marker), locks to the frame and distributes each slot into its own registered output. It sits downstream of the mux/serializer path and presents four parallel channels with a per-frame strobe and a sync-error flag.

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_slot_ctr.sv | 26 ++
 rtl/tdm_demux1x4.sv | 119 +++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM link definitions: slot count, slot index type and framer states.
// The transmit-side mux uses the same definitions.
package tdm_pkg;
   localparam int NSLOTS = 4;

   typedef logic [1:0] slot_t;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Mod-NSLOTS slot counter with clear, load-to-1 and increment-with-wrap.
// Priority order: reset, clear, load, increment.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  clr,
   input  logic  load1,
   input  logic  inc,
   output slot_t cnt
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load1) begin
         cnt <= slot_t'(1);
      end else if (inc) begin
         cnt <= cnt + slot_t'(1);
      end
   end

endmodule

// File: rtl/tdm_demux1x4.sv
// 1-to-4 time-division demultiplexer: locks to the slot-0 sync marker and
// presents each complete frame on four registered channel outputs.
module tdm_demux1x4
   import tdm_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   input  logic             sync,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic [1:0]       sel,
   output logic             locked,
   output logic             frame_valid,
   output logic             sync_err
);

   state_t           state;
   state_t           state_nxt;
   slot_t            slot;
   logic             ctr_clr;
   logic             ctr_load1;
   logic             ctr_inc;
   logic             shadow_wr;
   slot_t            shadow_idx;
   logic             frame_done;
   logic             err;
   logic [WIDTH-1:0] shadow [NSLOTS-1];

   tdm_slot_ctr u_slot_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ctr_clr),
      .load1 (ctr_load1),
      .inc   (ctr_inc),
      .cnt   (slot)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (en) begin
         unique case (state)
            HUNT:    if (sync) state_nxt = LOCK;
            LOCK:    if (slot == '0 && !sync) state_nxt = HUNT;
            default: state_nxt = HUNT;
         endcase
      end
   end

   // Per-sample decode: a sync always restarts the frame at slot 0, whatever
   // slot the counter expected; a missing sync at slot 0 drops lock.
   always_comb begin
      ctr_clr    = 1'b0;
      ctr_load1  = 1'b0;
      ctr_inc    = 1'b0;
      shadow_wr  = 1'b0;
      shadow_idx = slot;
      frame_done = 1'b0;
      err        = 1'b0;
      if (en) begin
         if (sync) begin
            ctr_load1  = 1'b1;
            shadow_wr  = 1'b1;
            shadow_idx = '0;
            err        = (state == LOCK) && (slot != '0);
         end else if (state == LOCK) begin
            if (slot == '0) begin
               err     = 1'b1;
               ctr_clr = 1'b1;
            end else if (slot == slot_t'(NSLOTS - 1)) begin
               frame_done = 1'b1;
               ctr_inc    = 1'b1;
            end else begin
               shadow_wr = 1'b1;
               ctr_inc   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NSLOTS - 1; i++) shadow[i] <= '0;
         y0          <= '0;
         y1          <= '0;
         y2          <= '0;
         y3          <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_valid <= frame_done;
         sync_err    <= err;
         if (shadow_wr) shadow[shadow_idx] <= din;
         if (frame_done) begin
            y0 <= shadow[0];
            y1 <= shadow[1];
            y2 <= shadow[2];
            y3 <= din;
         end
      end
   end

   assign sel    = slot;
   assign locked = (state == LOCK);

endmodule
